muxn_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one muxn datapath among 2**NB_SEL requesters.
- Grants one requester at a time and drives the registered binary select of an internal muxn instance.
- Supports grant locking while the owner holds its request, with an optional hold-time limit for fairness.
- Sits between client blocks and the shared bit-serial bus.

---
 rtl/muxn_rr_arbiter_pkg.sv | 11 +
 rtl/arb_defs.vh | 13 +
 rtl/muxn_rr_arbiter_muxn.sv | 12 +
 rtl/muxn_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_muxn_rr_arbiter.sv | 135 +++++++++++++
 5 files changed

// File: rtl/muxn_rr_arbiter_pkg.sv
// Types and constants shared by the round-robin arbiter and its bench.
package muxn_rr_arbiter_pkg;

`include "arb_defs.vh"

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } arb_state_e;

endpackage

// File: rtl/arb_defs.vh
// Shared arbiter definitions: state encodings and the cyclic index step.
// Included inside muxn_rr_arbiter_pkg so the localparams get package scope.
`ifndef ARB_DEFS_VH
`define ARB_DEFS_VH

localparam logic ST_IDLE  = 1'b0;
localparam logic ST_GRANT = 1'b1;

// Requester count is always a power of two, so the natural wrap of an
// NB_SEL-bit add gives the mod-N increment (N-1 -> 0).
`define ARB_NEXT_IDX(idx) ((idx) + 1'b1)

`endif

// File: rtl/muxn_rr_arbiter_muxn.sv
// Plain 2**NB_SEL:1 single-bit multiplexer with a binary select.
module muxn #(
  parameter int NB_SEL = 2
) (
  input  logic [(1<<NB_SEL)-1:0] ins,
  input  logic [NB_SEL-1:0]      sel,
  output logic                   out
);

  assign out = ins[sel];

endmodule

// File: rtl/muxn_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared muxn. Grants lock while
// the owner requests, with an optional hold limit that forces rotation.
module muxn_rr_arbiter
  import muxn_rr_arbiter_pkg::*;
#(
  parameter int NB_SEL   = 2,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [(1<<NB_SEL)-1:0] req,
  input  logic [(1<<NB_SEL)-1:0] data_in,
  output logic [(1<<NB_SEL)-1:0] gnt,
  output logic [NB_SEL-1:0]      sel,
  output logic                   busy,
  output logic                   data_out
);

  localparam int N = 1 << NB_SEL;
  localparam logic HOLD_EN = (MAX_HOLD > 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  arb_state_e        state, nxt_state;
  logic [NB_SEL-1:0] ptr, nxt_ptr;
  logic [NB_SEL-1:0] owner, nxt_owner;
  logic [HOLD_W-1:0] hold_cnt, nxt_cnt;

  logic              pick_vld;
  logic [NB_SEL-1:0] pick_idx;
  logic [NB_SEL-1:0] cand;
  logic [N-1:0]      others;
  logic              take;

  logic [N-1:0]      gnt_d;
  logic [NB_SEL-1:0] sel_d;
  logic              busy_d;
  logic              mux_out;

  // Cyclic first-set search starting at ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + NB_SEL'(i);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign others = req & ~(N'(1) << owner);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= nxt_state;
      ptr      <= nxt_ptr;
      owner    <= nxt_owner;
      hold_cnt <= nxt_cnt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_owner = owner;
    nxt_cnt   = hold_cnt;
    take      = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_vld) take = 1'b1;
      end
      S_GRANT: begin
        if (!req[owner]) begin
          // Owner bit is already clear, so the pick can only find others.
          if (pick_vld) take = 1'b1;
          else begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
          end
        end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
          // ptr is owner+1, so the owner is the last candidate searched.
          if (|others) take = 1'b1;
          else         nxt_cnt = '0;
        end else if (hold_cnt != '1) begin
          nxt_cnt = hold_cnt + 1'b1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
    if (take) begin
      nxt_state = S_GRANT;
      nxt_owner = pick_idx;
      nxt_ptr   = `ARB_NEXT_IDX(pick_idx);
      nxt_cnt   = '0;
    end
  end

  // Output decode from next state, registered below.
  always_comb begin
    busy_d = (nxt_state == S_GRANT);
    gnt_d  = busy_d ? (N'(1) << nxt_owner) : '0;
    sel_d  = busy_d ? nxt_owner : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt  <= '0;
      sel  <= '0;
      busy <= 1'b0;
    end else begin
      gnt  <= gnt_d;
      sel  <= sel_d;
      busy <= busy_d;
    end
  end

  muxn #(.NB_SEL(NB_SEL)) u_muxn (
    .ins (data_in),
    .sel (sel),
    .out (mux_out)
  );

  assign data_out = mux_out & busy;

endmodule

// File: tb/tb_muxn_rr_arbiter.sv
// Scoreboard bench for muxn_rr_arbiter (NB_SEL=2, MAX_HOLD=4).
module tb_muxn_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       data_out;

  typedef struct {
    string      nm;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       dout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  muxn_rr_arbiter #(.NB_SEL(2), .MAX_HOLD(4), .HOLD_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %b expected %b", nm, fld, act, exp);
    end
  endtask

  // Monitor: every edge presents a fresh registered output; sample 1 unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "gnt",  gnt,            e.gnt);
        chk(e.nm, "sel",  {2'b00, sel},   {2'b00, e.sel});
        chk(e.nm, "busy", {3'b000, busy}, {3'b000, e.busy});
        chk(e.nm, "dout", {3'b000, data_out}, {3'b000, e.dout});
      end
    end
  end

  // One clock edge with given inputs; expectation is the post-edge output.
  task automatic cyc(input string nm, input logic rn, input logic [3:0] r, input logic [3:0] d,
                     input logic [3:0] eg, input logic [1:0] es, input logic eb);
    exp_t e;
    rst_n = rn; req = r; data_in = d;
    e.nm = nm; e.gnt = eg; e.sel = es; e.busy = eb; e.dout = eb & d[es];
    exp_q.push_back(e);
    @(posedge clk);
    #3;
  endtask

  initial begin
    logic [3:0] g;
    rst_n = 1'b0; req = '0; data_in = '0;

    // Reset with everything requesting, then first grant from ptr=0.
    cyc("rst0",  1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("rst1",  1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("rel",   1'b1, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1);
    cyc("idle",  1'b1, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0);

    // Single client and data path masking.
    cyc("sgl_a", 1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1);
    cyc("sgl_b", 1'b1, 4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b1);
    cyc("sgl_c", 1'b1, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0);

    // Hold-limit rotation: 4 cycles each, no gaps.
    cyc("rot_r", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      g = 4'b0001 << ((c / 4) % 4);
      cyc($sformatf("rot%0d", c), 1'b1, 4'b1111, 4'b0101, g, 2'((c / 4) % 4), 1'b1);
    end

    // Wrap handoff 3 -> 0, then ptr=1 observed via next pick.
    cyc("wrp_r", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc("wrp_a", 1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1);
    cyc("wrp_b", 1'b1, 4'b1011, 4'b0001, 4'b1000, 2'd3, 1'b1);
    cyc("wrp_c", 1'b1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1);
    cyc("wrp_d", 1'b1, 4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1);

    // Sole requester across the hold limit, then same-edge handoff.
    cyc("sol_r", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int c = 0; c < 12; c++)
      cyc($sformatf("sol%0d", c), 1'b1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1);
    cyc("sim_h", 1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1);

    // Reset in the middle of a grant with hold_cnt=2.
    cyc("mid_r", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc("mid_a", 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1);
    cyc("mid_b", 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1);
    cyc("mid_c", 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1);
    cyc("mid_x", 1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("mid_g", 1'b1, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
